// File: rtl/fault_mgr_pkg.sv
// Shared types and helpers for the N-channel fault manager: state encoding,
// saturating step and lowest-index priority encode.
package fault_mgr_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'b00,
        ST_WARNING  = 2'b01,
        ST_FAULT    = 2'b10,
        ST_SHUTDOWN = 2'b11
    } fm_state_e;

    localparam int MAX_CH = 64;

    // Step to add to a saturating counter: +1, -1 or 0 at the rails.
    // Callers cast to their own width, so -1 wraps into a decrement.
    function automatic int sat_delta(input logic up, input logic at_max, input logic at_zero);
        int d;
        if (up) begin
            d = at_max ? 0 : 1;
        end else begin
            d = at_zero ? 0 : -1;
        end
        return d;
    endfunction

    function automatic int lowest_idx(input logic [MAX_CH-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fault_chan_qual.sv
// One fault channel: leaky-integrator counter with warning/fault qualifiers
// and a registered fault-qualified flag.
module fault_chan_qual
    import fault_mgr_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             raw_flt_i,
    input  logic             mask_i,
    input  logic [CNT_W-1:0] warn_thresh_i,
    input  logic [CNT_W-1:0] flt_thresh_i,
    output logic             warn_q_o,
    output logic             flt_q_o,
    output logic             flt_vec_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flt_vec_q;
    logic             eff;

    assign eff = raw_flt_i & ~mask_i;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(sat_delta(eff, &cnt_q, cnt_q == '0));
        if (mask_i) begin
            cnt_d = '0;
        end
    end

    // A zero threshold disables that qualifier entirely.
    assign warn_q_o = (warn_thresh_i != '0) && (cnt_q >= warn_thresh_i);
    assign flt_q_o  = (flt_thresh_i  != '0) && (cnt_q >= flt_thresh_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            flt_vec_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            flt_vec_q <= flt_q_o;
        end
    end

    assign flt_vec_o = flt_vec_q;

endmodule

// File: rtl/fault_mgr_nch.sv
// N-channel fault manager: per-channel qualification plus a global
// NORMAL/WARNING/FAULT/SHUTDOWN FSM. Optional timestamp capture: FAULT_TS_EN.
module fault_mgr_nch
    import fault_mgr_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 12,
    parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int TS_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] raw_flt_i,
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [NUM_CH-1:0] crit_i,
    input  logic [CNT_W-1:0]  warn_thresh_i,
    input  logic [CNT_W-1:0]  flt_thresh_i,
    input  logic [CNT_W-1:0]  esc_thresh_i,
    input  logic              fault_ack_i,
    output logic [1:0]        state_o,
    output logic              warning_o,
    output logic              fault_o,
    output logic              shutdown_o,
    output logic [NUM_CH-1:0] flt_vec_o,
    output logic [ID_W-1:0]   active_id_o,
    output logic [ID_W-1:0]   first_id_o,
    output logic              first_valid_o,
    output logic [TS_W-1:0]   first_ts_o
);

    logic [NUM_CH-1:0] warn_q, flt_q, flt_vec;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fault_chan_qual #(
            .CNT_W (CNT_W)
        ) u_qual (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .raw_flt_i     (raw_flt_i[g]),
            .mask_i        (mask_i[g]),
            .warn_thresh_i (warn_thresh_i),
            .flt_thresh_i  (flt_thresh_i),
            .warn_q_o      (warn_q[g]),
            .flt_q_o       (flt_q[g]),
            .flt_vec_o     (flt_vec[g])
        );
    end

    logic any_warn, any_flt, any_crit, esc_hit, capture;
    logic [MAX_CH-1:0] flt_q_ext, flt_vec_ext;
    logic [ID_W-1:0]   lowest_flt;

    assign any_warn = |warn_q;
    assign any_flt  = |flt_q;
    assign any_crit = |(flt_q & crit_i);

    always_comb begin
        flt_q_ext                = '0;
        flt_vec_ext              = '0;
        flt_q_ext[NUM_CH-1:0]    = flt_q;
        flt_vec_ext[NUM_CH-1:0]  = flt_vec;
    end

    assign lowest_flt  = ID_W'(lowest_idx(flt_q_ext));
    assign active_id_o = ID_W'(lowest_idx(flt_vec_ext));

    fm_state_e        state_q, state_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [ID_W-1:0]  first_id_q, first_id_d;
    logic             first_valid_q, first_valid_d;

    assign esc_hit = (esc_thresh_i != '0) && (dwell_q == esc_thresh_i);
    assign capture = (state_q == ST_WARNING) && any_flt && !first_valid_q;

    always_comb begin
        state_d       = state_q;
        dwell_d       = dwell_q;
        first_id_d    = first_id_q;
        first_valid_d = first_valid_q;
        case (state_q)
            ST_NORMAL: begin
                if (any_warn || any_flt) begin
                    state_d = ST_WARNING;
                end
            end
            ST_WARNING: begin
                if (any_flt) begin
                    state_d = ST_FAULT;
                    dwell_d = '0;
                end else if (!any_warn) begin
                    state_d = ST_NORMAL;
                end
            end
            ST_FAULT: begin
                dwell_d = dwell_q + CNT_W'(sat_delta(1'b1, &dwell_q, 1'b0));
                // Shutdown outranks an acknowledge arriving in the same cycle.
                if (any_crit || esc_hit) begin
                    state_d = ST_SHUTDOWN;
                end else if (fault_ack_i && !any_flt && !any_warn) begin
                    state_d = ST_NORMAL;
                end
            end
            ST_SHUTDOWN: begin
                state_d = ST_SHUTDOWN;
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase
        if (capture) begin
            first_id_d    = lowest_flt;
            first_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_NORMAL;
            dwell_q       <= '0;
            first_id_q    <= '0;
            first_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            first_id_q    <= first_id_d;
            first_valid_q <= first_valid_d;
        end
    end

`ifdef FAULT_TS_EN
    logic [TS_W-1:0] ts_q, first_ts_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_q       <= '0;
            first_ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (capture) begin
                first_ts_q <= ts_q;
            end
        end
    end

    assign first_ts_o = first_ts_q;
`else
    assign first_ts_o = {TS_W{1'b0}};
`endif

    assign state_o       = state_q;
    assign warning_o     = (state_q == ST_WARNING);
    assign fault_o       = (state_q == ST_FAULT);
    assign shutdown_o    = (state_q == ST_SHUTDOWN);
    assign flt_vec_o     = flt_vec;
    assign first_id_o    = first_id_q;
    assign first_valid_o = first_valid_q;

endmodule

// File: tb/tb_fault_mgr_nch.sv
// Bench for fault_mgr_nch: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the channel and state rules.
module tb_fault_mgr_nch;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 12;
    localparam int ID_W   = 3;
    localparam int TS_W   = 32;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] raw_flt, mask, crit;
    logic [CNT_W-1:0]  warn_thresh, flt_thresh, esc_thresh;
    logic              fault_ack;
    logic [1:0]        state;
    logic              warning, fault, shutdown;
    logic [NUM_CH-1:0] flt_vec;
    logic [ID_W-1:0]   active_id, first_id;
    logic              first_valid;
    logic [TS_W-1:0]   first_ts;

    always #5 clk = ~clk;

    fault_mgr_nch #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .ID_W   (ID_W),
        .TS_W   (TS_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .raw_flt_i     (raw_flt),
        .mask_i        (mask),
        .crit_i        (crit),
        .warn_thresh_i (warn_thresh),
        .flt_thresh_i  (flt_thresh),
        .esc_thresh_i  (esc_thresh),
        .fault_ack_i   (fault_ack),
        .state_o       (state),
        .warning_o     (warning),
        .fault_o       (fault),
        .shutdown_o    (shutdown),
        .flt_vec_o     (flt_vec),
        .active_id_o   (active_id),
        .first_id_o    (first_id),
        .first_valid_o (first_valid),
        .first_ts_o    (first_ts)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: integrator levels, registered flags, state code
    // (0 normal, 1 warning, 2 fault, 3 shutdown), cycles spent in fault so far.
    int              m_cnt [NUM_CH];
    logic [NUM_CH-1:0] m_fvec;
    int              m_state, m_dwell, m_fid;
    logic            m_fval;
    logic [TS_W-1:0] m_ts, m_fts;

    function automatic int first_set(input logic [NUM_CH-1:0] v);
        for (int i = 0; i < NUM_CH; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic tick();
        int              n_cnt [NUM_CH];
        logic [NUM_CH-1:0] wq, fq;
        int              n_state, n_dwell, n_fid;
        logic            n_fval;
        logic [TS_W-1:0] n_fts;
        bit              any_w, any_f, crit_f;
        for (int i = 0; i < NUM_CH; i++) begin
            wq[i] = (warn_thresh != 0) && (m_cnt[i] >= int'(warn_thresh));
            fq[i] = (flt_thresh  != 0) && (m_cnt[i] >= int'(flt_thresh));
            if (mask[i])         n_cnt[i] = 0;
            else if (raw_flt[i]) n_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
            else                 n_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
        any_w  = |wq;
        any_f  = |fq;
        crit_f = |(fq & crit);
        n_state = m_state;
        if (m_state == 0 && (any_w || any_f)) n_state = 1;
        else if (m_state == 1) n_state = any_f ? 2 : (any_w ? 1 : 0);
        else if (m_state == 2) begin
            if (crit_f || (esc_thresh != 0 && m_dwell == int'(esc_thresh))) n_state = 3;
            else if (fault_ack && !any_f && !any_w) n_state = 0;
        end
        n_dwell = (m_state == 2 && n_state == 2) ? ((m_dwell < CMAX) ? m_dwell + 1 : CMAX) : 0;
        n_fval = m_fval;
        n_fid  = m_fid;
        n_fts  = m_fts;
        if (!m_fval && m_state == 1 && n_state == 2) begin
            n_fval = 1'b1;
            n_fid  = first_set(fq);
            n_fts  = m_ts;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_fvec = '0; m_state = 0; m_dwell = 0; m_fid = 0;
            m_fval = 1'b0; m_ts = '0; m_fts = '0;
        end else begin
            foreach (m_cnt[i]) m_cnt[i] = n_cnt[i];
            m_fvec = fq; m_state = n_state; m_dwell = n_dwell; m_fid = n_fid;
            m_fval = n_fval; m_ts = m_ts + 1'b1; m_fts = n_fts;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state",       64'(state),       64'(m_state));
            chk("warning",     64'(warning),     64'(m_state == 1));
            chk("fault",       64'(fault),       64'(m_state == 2));
            chk("shutdown",    64'(shutdown),    64'(m_state == 3));
            chk("flt_vec",     64'(flt_vec),     64'(m_fvec));
            chk("active_id",   64'(active_id),   64'(first_set(m_fvec)));
            chk("first_valid", 64'(first_valid), 64'(m_fval));
            chk("first_id",    64'(first_id),    64'(m_fid));
`ifdef FAULT_TS_EN
            chk("first_ts",    64'(first_ts),    64'(m_fts));
`else
            chk("first_ts",    64'(first_ts),    64'(0));
`endif
        end
    end

    initial begin
        rst = 1'b1; raw_flt = '0; mask = '0; crit = '0; fault_ack = 1'b0;
        warn_thresh = 12'd8; flt_thresh = 12'd20; esc_thresh = 12'd0;
        do_reset();
        cmp_en = 1'b1;
        chk("rst_state", 64'(state), 64'(0));
        chk("rst_first_valid", 64'(first_valid), 64'(0));

        // Transient on ch3 never leaves NORMAL, then a full burst proves the count drained.
        raw_flt = 8'h08; run(5);
        raw_flt = 8'h00; run(5);
        chk("transient_state", 64'(state), 64'(0));
        raw_flt = 8'h08; run(8);
        chk("transient_refill_normal", 64'(state), 64'(0));
        tick();
        chk("transient_refill_warn", 64'(state), 64'(1));
        raw_flt = 8'h00;

        // Timed escalation on ch1.
        do_reset();
        esc_thresh = 12'd50; raw_flt = 8'h02;
        run(8);  chk("esc_pre_warn", 64'(state), 64'(0));
        tick();  chk("esc_warn", 64'(state), 64'(1));
        run(11); chk("esc_pre_fault", 64'(state), 64'(1));
        tick();  chk("esc_fault", 64'(state), 64'(2));
        run(50); chk("esc_pre_shut", 64'(state), 64'(2));
        tick();  chk("esc_shut", 64'(state), 64'(3));
        chk("esc_first_id", 64'(first_id), 64'(1));
        chk("esc_first_valid", 64'(first_valid), 64'(1));
        run(5);  chk("shut_absorbing", 64'(state), 64'(3));

        // Critical ch6 walks through every state; ack in the FAULT cycle is ignored.
        raw_flt = 8'h00; esc_thresh = 12'd0;
        do_reset();
        crit = 8'h40; raw_flt = 8'h40;
        run(9);  chk("crit_warn", 64'(state), 64'(1));
        run(12); chk("crit_fault", 64'(state), 64'(2));
        fault_ack = 1'b1; tick(); fault_ack = 1'b0;
        chk("crit_shut", 64'(state), 64'(3));

        // Ack-gated recovery on ch2, then a later fault on ch5.
        crit = 8'h00; raw_flt = 8'h00;
        do_reset();
        raw_flt = 8'h04; run(21);
        chk("ack_fault", 64'(state), 64'(2));
        raw_flt = 8'h00; run(5);
        fault_ack = 1'b1; tick(); fault_ack = 1'b0;
        chk("ack_early_ignored", 64'(state), 64'(2));
        run(7);
        fault_ack = 1'b1; tick(); fault_ack = 1'b0;
        chk("ack_at_warn_level", 64'(state), 64'(2));
        fault_ack = 1'b1; tick(); fault_ack = 1'b0;
        chk("ack_recover", 64'(state), 64'(0));
        raw_flt = 8'h20; run(21);
        chk("second_fault", 64'(state), 64'(2));
        chk("first_id_kept", 64'(first_id), 64'(2));

        // Mask and priority between ch4 and ch7.
        raw_flt = 8'h00;
        do_reset();
        raw_flt = 8'h90; run(25);
        chk("prio_active", 64'(active_id), 64'(4));
        chk("prio_vec", 64'(flt_vec), 64'(8'h90));
        mask = 8'h10; run(2);
        chk("mask_active", 64'(active_id), 64'(7));
        chk("mask_vec4", 64'(flt_vec[4]), 64'(0));

        // Reset in the middle of FAULT clears everything.
        chk("pre_rst_fault", 64'(state), 64'(2));
        do_reset();
        chk("rst_mid_state", 64'(state), 64'(0));
        chk("rst_mid_vec", 64'(flt_vec), 64'(0));
        chk("rst_mid_fv", 64'(first_valid), 64'(0));
        chk("rst_mid_ts", 64'(first_ts), 64'(0));
        mask = 8'h00; raw_flt = 8'h00;

        // Integrator saturation at full scale.
        do_reset();
        warn_thresh = 12'hFFF; flt_thresh = 12'hFFF; raw_flt = 8'h01;
        run(CMAX);
        chk("sat_not_yet", 64'(flt_vec[0]), 64'(0));
        tick();
        chk("sat_reached", 64'(flt_vec[0]), 64'(1));
        run(20);
        chk("sat_held", 64'(flt_vec[0]), 64'(1));
        raw_flt = 8'h00; run(2);
        chk("sat_release", 64'(flt_vec[0]), 64'(0));

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                warn_thresh = CNT_W'($urandom_range(0, 12));
                flt_thresh  = CNT_W'($urandom_range(0, 24));
                esc_thresh  = CNT_W'($urandom_range(0, 30));
                crit        = NUM_CH'($urandom) & NUM_CH'($urandom);
            end
            raw_flt = raw_flt ^ (NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom));
            if ($urandom_range(0, 31) == 0) mask = mask ^ (NUM_CH'(1) << $urandom_range(0, NUM_CH - 1));
            fault_ack = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0; fault_ack = 1'b0;
        run(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
